// File: rtl/cordic_out_skid.sv
// rtl/cordic_out_skid.sv - CORDIC output stage: gain compensation into a 2-entry registered skid buffer
//
// Purpose:
//   Takes the last CORDIC pipeline stage's valid/ready stream (x, y, z) and
//   optionally scales x/y by 1/K. The result is presented on a registered
//   AXI-Stream-like master. s_tready is a flop, so m_tready never reaches
//   back into the pipeline combinationally.
//
// Build option:
//   CORDIC_OUT_GAIN_COMP_EN - when defined, x/y are multiplied by K_INV
//   (unsigned Q1.15) and rounded half up. When undefined, x/y pass through
//   bit-exact and K_INV is ignored.
//
// Ports:
//   aclk, aresetn      clock, synchronous active-low reset
//   s_tvalid/s_tready  upstream handshake (s_tready registered)
//   s_x, s_y, s_z      upstream sample (signed x/y, residual angle z)
//   m_tvalid/m_tready  downstream handshake
//   m_x, m_y, m_z      compensated x/y, unmodified z
module cordic_out_skid #(
    parameter int          DATA_WIDTH  = 16,
    parameter int          ANGLE_WIDTH = 16,
    parameter logic [15:0] K_INV       = 16'h4DBB
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    input  logic [DATA_WIDTH-1:0]  s_x,
    input  logic [DATA_WIDTH-1:0]  s_y,
    input  logic [ANGLE_WIDTH-1:0] s_z,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic [DATA_WIDTH-1:0]  m_x,
    output logic [DATA_WIDTH-1:0]  m_y,
    output logic [ANGLE_WIDTH-1:0] m_z
);

    localparam int BEAT_W = 2 * DATA_WIDTH + ANGLE_WIDTH;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [DATA_WIDTH-1:0] comp_x;
    logic [DATA_WIDTH-1:0] comp_y;

`ifdef CORDIC_OUT_GAIN_COMP_EN
    localparam int PROD_W = DATA_WIDTH + 17;
    localparam logic signed [PROD_W-1:0] ROUND_HALF = PROD_W'(1) << 14;

    // K_INV is below 1.0, so the rounded product always fits back into
    // DATA_WIDTH bits; the final truncation drops only sign copies.
    function automatic logic [DATA_WIDTH-1:0] gain_comp(input logic [DATA_WIDTH-1:0] v);
        logic signed [PROD_W-1:0] prod;
        logic signed [PROD_W-1:0] sum;
        prod = $signed({{17{v[DATA_WIDTH-1]}}, v})
             * $signed({{DATA_WIDTH{1'b0}}, 1'b0, K_INV});
        sum  = prod + ROUND_HALF;
        return DATA_WIDTH'(sum >>> 15);
    endfunction

    assign comp_x = gain_comp(s_x);
    assign comp_y = gain_comp(s_y);
`else
    assign comp_x = s_x;
    assign comp_y = s_y;
`endif

    logic [1:0]        state_q,    state_d;
    logic [BEAT_W-1:0] main_q,     main_d;
    logic [BEAT_W-1:0] skid_q,     skid_d;
    logic              s_tready_q, s_tready_d;

    logic              in_fire;
    logic              out_fire;
    logic [BEAT_W-1:0] new_beat;

    assign new_beat = {comp_x, comp_y, s_z};
    assign m_tvalid = (state_q != ST_EMPTY);
    assign s_tready = s_tready_q;
    assign in_fire  = s_tvalid && s_tready_q;
    assign out_fire = m_tvalid && m_tready;
    assign {m_x, m_y, m_z} = main_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    main_d  = new_beat;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    main_d = new_beat;
                end else if (in_fire) begin
                    // Downstream stalled: park the new beat so main stays stable.
                    skid_d  = new_beat;
                    state_d = ST_FULL;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // s_tready is low here, so in_fire cannot occur.
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        // Ready is decided from the next state, so it can be registered.
        s_tready_d = (state_d != ST_FULL);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q    <= ST_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            s_tready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            s_tready_q <= s_tready_d;
        end
    end

endmodule

// File: tb/tb_cordic_out_skid.sv
// tb/tb_cordic_out_skid.sv - scoreboard bench for cordic_out_skid
module tb_cordic_out_skid;

    localparam int          DW = 16;
    localparam int          AW = 16;
    localparam logic [15:0] K  = 16'h4DBB;
    localparam int          BW = 2 * DW + AW;

    localparam int MODE_READY = 0;
    localparam int MODE_ALT   = 1;
    localparam int MODE_RAND  = 2;
    localparam int MODE_STALL = 3;

    logic          aclk;
    logic          aresetn;
    logic          s_tvalid;
    logic          s_tready;
    logic [DW-1:0] s_x;
    logic [DW-1:0] s_y;
    logic [AW-1:0] s_z;
    logic          m_tvalid;
    logic          m_tready;
    logic [DW-1:0] m_x;
    logic [DW-1:0] m_y;
    logic [AW-1:0] m_z;

    int n_cmp = 0;
    int n_bad = 0;
    logic [BW-1:0] exp_q[$];
    bit will_accept = 1'b0;
    bit rst_seen = 1'b0;

    cordic_out_skid #(
        .DATA_WIDTH (DW),
        .ANGLE_WIDTH(AW),
        .K_INV      (K)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s_tvalid(s_tvalid),
        .s_tready(s_tready),
        .s_x     (s_x),
        .s_y     (s_y),
        .s_z     (s_z),
        .m_tvalid(m_tvalid),
        .m_tready(m_tready),
        .m_x     (m_x),
        .m_y     (m_y),
        .m_z     (m_z)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: y = floor((v * K + 2^14) / 2^15) using plain integer arithmetic.
    function automatic logic [DW-1:0] model(input logic [DW-1:0] v);
`ifdef CORDIC_OUT_GAIN_COMP_EN
        longint num;
        longint q;
        num = longint'($signed(v)) * longint'(K) + 64'sd16384;
        q   = (num >= 0) ? num / 32768 : -((-num + 32767) / 32768);
        return DW'(q);
`else
        return v;
`endif
    endfunction

    // Input side: record every accepted beat as an expected output.
    always @(negedge aclk) begin
        #1;
        will_accept = aresetn && s_tvalid && s_tready;
        if (will_accept)
            exp_q.push_back({model(s_x), model(s_y), s_z});
    end

    // Output side: occupancy-derived handshake checks and in-order data checks.
    always @(negedge aclk) begin
        logic [BW-1:0] e;
        if (!aresetn) begin
            if (rst_seen) begin
                chk("rst_m_tvalid", m_tvalid, 0);
                chk("rst_s_tready", s_tready, 1);
            end
            rst_seen = 1'b1;
            exp_q.delete();
        end else begin
            rst_seen = 1'b0;
            chk("m_tvalid_vs_occupancy", m_tvalid, exp_q.size() > 0);
            chk("s_tready_vs_occupancy", s_tready, exp_q.size() < 2);
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("m_x", m_x, e[BW-1 -: DW]);
                    chk("m_y", m_y, e[AW +: DW]);
                    chk("m_z", m_z, e[AW-1:0]);
                end
            end
        end
    end

    // Issues nbeats upstream beats; m_tready follows the chosen pattern.
    task automatic run(input int nbeats, input int mode, input bit seq_x);
        int acc = 0;
        int issued = 0;
        int cyc = 0;
        int limit = nbeats * 20 + 50;
        while (acc < nbeats && cyc < limit) begin
            case (mode)
                MODE_READY: m_tready = 1'b1;
                MODE_ALT:   m_tready = (cyc % 2) == 0;
                MODE_RAND:  m_tready = $urandom_range(3) != 0;
                default:    m_tready = (cyc >= 8);
            endcase
            if (!s_tvalid && issued < nbeats && (mode != MODE_RAND || $urandom_range(3) != 0)) begin
                s_x      = seq_x ? DW'(issued) : DW'($urandom);
                s_y      = DW'($urandom);
                s_z      = AW'($urandom);
                s_tvalid = 1'b1;
                issued++;
            end
            @(posedge aclk); #1;
            if (will_accept) begin
                acc++;
                s_tvalid = 1'b0;
            end
            cyc++;
        end
        chk("run_all_accepted", acc, nbeats);
        s_tvalid = 1'b0;
    endtask

    task automatic drain();
        int c = 0;
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        while (exp_q.size() != 0 && c < 50) begin
            @(posedge aclk); #1;
            c++;
        end
        repeat (2) @(posedge aclk);
        #1;
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        aresetn  = 1'b0;
        s_tvalid = 1'b1;
        s_x      = 16'd100;
        s_y      = 16'd0;
        s_z      = 16'd0;
        m_tready = 1'b1;

        // Reset with a pending upstream beat that must be ignored.
        repeat (3) @(posedge aclk);
        #1;
        aresetn  = 1'b1;
        s_tvalid = 1'b0;
        repeat (4) @(posedge aclk);
        #1;

        // Single directed beat with known result.
        s_x      = 16'sd10000;
        s_y      = -16'sd10000;
        s_z      = 16'h1234;
        s_tvalid = 1'b1;
        m_tready = 1'b1;
        @(posedge aclk); #1;
        s_tvalid = 1'b0;
        @(negedge aclk);
        chk("single_m_tvalid", m_tvalid, 1);
`ifdef CORDIC_OUT_GAIN_COMP_EN
        chk("single_m_x", m_x, 16'd6073);
        chk("single_m_y", m_y, 16'hE847);
`else
        chk("single_m_x", m_x, 16'd10000);
        chk("single_m_y", m_y, 16'hD8F0);
`endif
        chk("single_m_z", m_z, 16'h1234);
        @(posedge aclk); #1;
        drain();

        // Backpressure: two beats absorbed, third held until ready returns.
        run(4, MODE_STALL, 1'b1);
        drain();

        // Full-rate streaming.
        run(16, MODE_READY, 1'b1);
        drain();

        // Alternating ready with continuous input.
        run(40, MODE_ALT, 1'b0);
        drain();

        // Fill both entries, then reset: old beats must not reappear.
        run(2, MODE_STALL, 1'b0);
        aresetn = 1'b0;
        @(posedge aclk); #1;
        aresetn  = 1'b1;
        m_tready = 1'b1;
        repeat (4) @(posedge aclk);
        #1;

        // Random traffic.
        run(300, MODE_RAND, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cordic_out_skid.md
Name: cordic_out_skid

Overview:
Output stage placed directly downstream of the CORDIC pipeline control chain. It consumes the last pipeline stage's valid/ready stream (x, y, z) and applies CORDIC gain compensation (x, y multiplied by 1/K). It presents the result on a registered AXI-Stream master through a 2-entry skid buffer, so s_tready is a registered signal. This breaks the combinational ready path that otherwise runs from m_tready back through every pipeline stage.

Parameters:
DATA_WIDTH, 16, width of signed x/y samples.
ANGLE_WIDTH, 16, width of z (residual angle), passed through unchanged.
K_INV, 16'h4DBB, gain-compensation constant in unsigned Q1.15 (0.60725), valid range 0..16'h7FFF.

Ports:
aclk  in  1  clock.
aresetn  in  1  synchronous active-low reset.
s_tvalid  in  1  upstream valid (from last pipeline stage).
s_tready  out  1  upstream ready; registered.
s_x  in  DATA_WIDTH  signed x from pipeline.
s_y  in  DATA_WIDTH  signed y from pipeline.
s_z  in  ANGLE_WIDTH  z from pipeline.
m_tvalid  out  1  downstream valid.
m_tready  in  1  downstream ready.
m_x  out  DATA_WIDTH  compensated x.
m_y  out  DATA_WIDTH  compensated y.
m_z  out  ANGLE_WIDTH  z, unmodified.

Behaviour:
- Reset: aresetn synchronous, active-low; clock aclk. On reset: state EMPTY, m_tvalid=0, s_tready=1, m_x/m_y/m_z=0, skid data=0. Handshakes presented while aresetn=0 are ignored.
- Handshakes: upstream transfer when s_tvalid&&s_tready; downstream transfer when m_tvalid&&m_tready. Once m_tvalid=1, m_tvalid and m_* stay stable until the transfer completes.
- Storage: main register (drives m_*) and skid register. Gain compensation is computed combinationally on s_x/s_y before capture.
- States:
  - EMPTY: m_tvalid=0, s_tready=1.
  - ONE: main holds one beat, m_tvalid=1, s_tready=1.
  - FULL: main and skid both hold a beat, m_tvalid=1, s_tready=0.
- EMPTY: upstream transfer -> main<=new, go ONE. Otherwise stay.
- ONE:
  - in and out in the same cycle -> main<=new, stay ONE.
  - in only -> skid<=new, go FULL.
  - out only -> go EMPTY.
  - neither -> stay.
- FULL: out -> main<=skid, go ONE. Otherwise stay. No input is accepted in FULL.
- s_tready is registered: s_tready=(next_state!=FULL). It never depends combinationally on m_tready.
- Latency: 1 cycle from accepted input to m_tvalid. Throughput is 1 beat/cycle when m_tready=1. Output order equals input order, with no loss or duplication.
- Arithmetic: prod = s_x * $signed({1'b0,K_INV}), width DATA_WIDTH+17. Result = (prod + 2^14) >>> 15, truncated to DATA_WIDTH (round half up). y is treated identically.
  - Since K_INV<1.0, the result always fits; no saturation logic.
  - K_INV=0 gives 0.
- Reset mid-operation: buffered beats are discarded and m_tvalid=0 from the cycle after reset is sampled.

Optional Feature:
Macro CORDIC_OUT_GAIN_COMP_EN.
- Defined: x/y are scaled by K_INV as above.
- Undefined: multiplier is removed; m_x/m_y carry s_x/s_y bit-exact. Latency, handshake and K_INV parameter (unused) are unchanged.

Test Plan:
1. Reset: aresetn=0 for 3 cycles with s_tvalid=1, s_x=100 -> m_tvalid=0 throughout; after release s_tready=1, no output beat appears.
2. Single beat with macro defined: s_x=10000, s_y=-10000, s_z=16'h1234, m_tready=1 -> next cycle m_tvalid=1, m_x=6073, m_y=-6073, m_z=16'h1234. With macro undefined -> m_x=10000, m_y=-10000.
3. Backpressure: m_tready=0, s_tvalid=1 with beats A,B,C,D:
   - A and B are accepted.
   - s_tready=0 from the cycle after B is accepted; C is held stable upstream.
   - Raise m_tready -> outputs A,B,C,D in order, one per cycle, no loss.
4. Streaming: s_tvalid=1 and m_tready=1 for 16 cycles with s_x=0..15 -> m_tvalid=1 for 16 consecutive cycles starting 1 cycle later; s_tready never drops.
5. Simultaneous in/out in ONE: alternate m_tready 1/0 each cycle with continuous input -> no beat dropped; FULL reached, s_tready toggles, sequence preserved.
6. Reset in FULL: fill both entries, assert aresetn=0 for 1 cycle -> next cycle m_tvalid=0, s_tready=1; the old beats never appear on m_*.
